// File: rtl/acia_pkg.sv
// Shared ACIA definitions: receiver state encodings, parity modes and
// default timing parameters used by both the receive and transmit halves.
package acia_pkg;

  localparam int OVERSAMPLE_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_PARITY    = 3'd3;
  localparam logic [2:0] RX_STOP      = 3'd4;
  localparam logic [2:0] RX_BREAKWAIT = 3'd5;

  localparam logic [1:0] PM_ODD   = 2'b00;
  localparam logic [1:0] PM_EVEN  = 2'b01;
  localparam logic [1:0] PM_MARK  = 2'b10;
  localparam logic [1:0] PM_SPACE = 2'b11;

  // par is the XOR of the eight data bits; bit_in is the sampled parity bit.
  function automatic logic parity_error(input logic [1:0] mode,
                                        input logic       par,
                                        input logic       bit_in);
    logic err;
    case (mode)
      PM_ODD:   err = ~(par ^ bit_in);
      PM_EVEN:  err = par ^ bit_in;
      PM_MARK:  err = ~bit_in;
      default:  err = bit_in;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/acia_rx_if.sv
// CPU-side and line-side signals of the ACIA receiver, plus the FSM state
// for observation. The CPU reads RXDATA when RXFULL=1 and pulses RXREAD for
// one PHI2 cycle; that pulse is the only acknowledgement and clears RXFULL.
interface acia_rx_if;
  logic       BTICK;
  logic       RXD;
  logic       R_PME;
  logic [1:0] R_PMC;
  logic       RXREAD;
  logic [7:0] RXDATA;
  logic       RXFULL;
  logic       PERR;
  logic       FERR;
  logic       OVERRUN;
  logic [2:0] rx_state;

  modport master (
    output BTICK, RXD, R_PME, R_PMC, RXREAD,
    input  RXDATA, RXFULL, PERR, FERR, OVERRUN, rx_state
  );

  modport slave (
    input  BTICK, RXD, R_PME, R_PMC, RXREAD,
    output RXDATA, RXFULL, PERR, FERR, OVERRUN, rx_state
  );
endinterface

// File: rtl/acia_sync.sv
// Flop chain synchroniser for an asynchronous level input. Resets to 1 so an
// idle-high line never looks like a start edge coming out of reset.
module acia_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/acia_rx.sv
// ACIA receiver: oversampled start detection, 8 data bits LSB first,
// optional parity, stop check, and a single holding register with status.
module acia_rx
  import acia_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       PHI2,
  input  logic       RESET,
  acia_rx_if.slave   bus
);

  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

  logic rxs;

  acia_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (PHI2),
    .rst (RESET),
    .d   (bus.RXD),
    .q   (rxs)
  );

  logic [2:0]    state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q,   shift_d;
  logic          par_q,     par_d;
  logic          perr_n_q,  perr_n_d;
  logic [7:0]    rxdata_q,  rxdata_d;
  logic          rxfull_q,  rxfull_d;
  logic          perr_q,    perr_d;
  logic          ferr_q,    ferr_d;
  logic          overrun_q, overrun_d;
  logic          complete;
  logic          ferr_n;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    perr_n_d  = perr_n_q;
    complete  = 1'b0;
    ferr_n    = 1'b0;

    if (bus.BTICK) begin
      case (state_q)
        RX_IDLE: begin
          if (!rxs) begin
            cnt_d   = '0;
            state_d = RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == CNT_MID) begin
            if (!rxs) begin
              cnt_d     = '0;
              bit_cnt_d = '0;
              par_d     = 1'b0;
              perr_n_d  = 1'b0;
              state_d   = RX_DATA;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_END) begin
            cnt_d     = '0;
            shift_d   = {rxs, shift_q[7:1]};
            par_d     = par_q ^ rxs;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = bus.R_PME ? RX_PARITY : RX_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RX_PARITY: begin
          if (cnt_q == CNT_END) begin
            cnt_d    = '0;
            perr_n_d = parity_error(bus.R_PMC, par_q, rxs);
            state_d  = RX_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == CNT_END) begin
            cnt_d    = '0;
            ferr_n   = ~rxs;
            complete = 1'b1;
            state_d  = rxs ? RX_IDLE : RX_BREAKWAIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RX_BREAKWAIT: begin
          // A held-low line must return high before another start is armed.
          if (rxs) state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rxdata_d  = rxdata_q;
    rxfull_d  = rxfull_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = overrun_q;

    if (bus.RXREAD) begin
      rxfull_d  = 1'b0;
      overrun_d = 1'b0;
    end

    // A read in the completion cycle frees the register, so the new byte loads.
    if (complete) begin
      if (!rxfull_q || bus.RXREAD) begin
        rxdata_d = shift_q;
        rxfull_d = 1'b1;
        perr_d   = perr_n_q;
        ferr_d   = ferr_n;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge PHI2) begin
    if (RESET) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      perr_n_q  <= 1'b0;
      rxdata_q  <= 8'h00;
      rxfull_q  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      perr_n_q  <= perr_n_d;
      rxdata_q  <= rxdata_d;
      rxfull_q  <= rxfull_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.RXDATA   = rxdata_q;
  assign bus.RXFULL   = rxfull_q;
  assign bus.PERR     = perr_q;
  assign bus.FERR     = ferr_q;
  assign bus.OVERRUN  = overrun_q;
  assign bus.rx_state = state_q;

endmodule

// File: doc/acia_rx.md
Name: acia_rx

Overview:
- Receive half of the 6551-style ACIA: deserialises the RXD line into bytes for the CPU-side register file.
- Frame format is the one the transmitter generates: 1 start bit, 8 data bits LSB first, optional parity per R_PME/R_PMC, 1 or 2 stop bits.
- Runs entirely on PHI2. Bit timing comes from BTICK, a one-cycle enable at 16x the baud rate, produced by the baud generator.
- Presents a holding register with full, parity, framing and overrun status.

Parameters:
OVERSAMPLE, 16, BTICKs per bit; must be a power of two, at least 8.
SYNC_STAGES, 2, flops in the RXD synchroniser.

Ports:
PHI2  in  1  sole clock, rising edge.
RESET  in  1  synchronous reset, active-high.
BTICK  in  1  16x baud enable, one PHI2 cycle wide.
RXD  in  1  asynchronous serial input; idles high.
R_PME  in  1  parity enable.
R_PMC  in  2  parity mode: 00 odd, 01 even, 10 mark, 11 space.
RXREAD  in  1  CPU read strobe of the data register, one PHI2 cycle wide.
RXDATA  out  8  received byte holding register.
RXFULL  out  1  holding register holds an unread byte.
PERR  out  1  parity error for the byte in RXDATA.
FERR  out  1  framing error (stop bit sampled low) for the byte in RXDATA.
OVERRUN  out  1  a completed frame was discarded because RXFULL was set.

Behaviour:
- Reset: synchronous; RESET high at a PHI2 edge forces FSM to IDLE, bit counter and tick counter to 0, RXDATA=8'h00, and RXFULL, PERR, FERR, OVERRUN to 0. Synchroniser flops reset to 1.
- Reset mid-frame discards the partial frame; no status is updated.
- rxs is RXD after SYNC_STAGES flops. All state-machine activity below advances only on cycles where BTICK=1. Exception: RXREAD is processed every cycle.
- IDLE: on a tick with rxs=0, clear tick counter cnt, go to START.
- START: cnt increments each tick. At cnt=OVERSAMPLE/2-1 (tick 8, mid-bit):
  - rxs=0: cnt=0, bit counter=0, clear running parity, go to DATA.
  - rxs=1: glitch; return to IDLE with no status change.
- DATA: at cnt=OVERSAMPLE-1:
  - Sample rxs into shift register bit 7 while shifting right, so the first bit ends at bit 0.
  - XOR the sample into running parity; cnt=0.
  - After 8 bits go to PARITY if R_PME=1, else STOP.
- PARITY: at cnt=OVERSAMPLE-1, sample rxs and compute perr_n:
  - odd: perr_n = (par XOR rxs) = 0
  - even: perr_n = (par XOR rxs) = 1
  - mark: perr_n = (rxs = 0)
  - space: perr_n = (rxs = 1)
  - Then go to STOP.
- STOP: at cnt=OVERSAMPLE-1, sample rxs; ferr_n = ~rxs. Perform completion. Go to IDLE if rxs=1, else BREAKWAIT.
  - Only the first stop bit is checked; a second stop bit is indistinguishable from idle.
- BREAKWAIT: remain until a tick with rxs=1, then IDLE. This prevents a held-low line from retriggering frames.
- Completion, on the same PHI2 edge as the stop sample:
  - If RXFULL=0, or RXREAD=1 in this cycle: load RXDATA, set RXFULL=1, PERR=perr_n (0 when R_PME=0), FERR=ferr_n.
  - Otherwise: set OVERRUN=1; RXDATA, PERR and FERR keep the old byte's values.
- RXREAD=1 clears RXFULL and OVERRUN. When RXREAD coincides with completion, the load wins: RXFULL stays 1 and OVERRUN ends 0.
- Latency: RXFULL rises on the PHI2 edge of the stop-bit sample tick. That is about 9.5 bit times after the start edge for 8N1, plus synchroniser delay.
- R_PME/R_PMC are sampled when PARITY is entered/evaluated. Changing them mid-frame is undefined for that frame only.

Decomposition:
- Shared package acia_pkg: RX state encodings (IDLE, START, DATA, PARITY, STOP, BREAKWAIT); parity mode constants PM_ODD=2'b00, PM_EVEN=2'b01, PM_MARK=2'b10, PM_SPACE=2'b11 (shared with the transmitter); OVERSAMPLE default.
- One sub-module: acia_sync, a SYNC_STAGES-deep reset-to-1 flop chain, reusable for CTSB/DCD.

Test Plan:
- 8N1 byte 8'hA5 at 16x ticks: RXFULL=1, RXDATA=8'hA5, PERR=0, FERR=0. Then RXREAD for 1 cycle: RXFULL=0.
- R_PME=1 with each R_PMC, byte 8'h03:
  - correct parity bits (odd→1, even→0, mark→1, space→0): PERR=0.
  - each bit inverted: PERR=1, RXDATA=8'h03.
- Start pulse low for 4 ticks only: FSM returns to IDLE, RXFULL stays 0. Following valid 8'h5A is received correctly.
- Stop bit driven low, line held low 40 ticks, then high, then 8'h11: first frame FERR=1. No spurious frame during the low hold. 8'h11 received with FERR=0.
- Two frames 8'h01 then 8'h02, no RXREAD: RXDATA=8'h01, OVERRUN=1. Then RXREAD issued exactly on the completion cycle of a third frame 8'h03: RXDATA=8'h03, RXFULL=1, OVERRUN=0.
- RESET asserted during DATA bit 4: all outputs 0 next cycle. Next full frame 8'hFF is received correctly.
